// File: rtl/rx_fft_framer_if.sv
// Streaming bus between the receive framer and the parallel-4 FFT.
// Upstream side carries one enable-qualified beat of two complex samples per
// clock; downstream side carries one 4-lane word with frame markers.
// Handshake: a word moves when o_valid && i_ready on the same rising edge;
// while o_valid && !i_ready the word and its markers hold still, and o_valid
// never drops without a transfer.
// Optional macro RX_FRAMER_STATS_EN adds the o_sat_count statistics signal.
interface rx_fft_framer_if #(
    parameter int NB_IN  = 16,
    parameter int NB_OUT = 10
) ();
    logic                  i_enable;
    logic [NB_IN-1:0]      i_r1i;
    logic [NB_IN-1:0]      i_r1q;
    logic [NB_IN-1:0]      i_r2i;
    logic [NB_IN-1:0]      i_r2q;
    logic                  i_ready;
    logic                  o_valid;
    logic [4*NB_OUT-1:0]   o_data_i;
    logic [4*NB_OUT-1:0]   o_data_q;
    logic                  o_sof;
    logic                  o_eof;
    logic                  o_overflow;
`ifdef RX_FRAMER_STATS_EN
    logic [15:0]           o_sat_count;
`endif

    // Framer side: consumes samples and ready, produces words.
    modport slave (
`ifdef RX_FRAMER_STATS_EN
        output o_sat_count,
`endif
        input  i_enable, i_r1i, i_r1q, i_r2i, i_r2q, i_ready,
        output o_valid, o_data_i, o_data_q, o_sof, o_eof, o_overflow
    );

    // Environment side: drives samples and ready, observes words.
    modport master (
`ifdef RX_FRAMER_STATS_EN
        input  o_sat_count,
`endif
        output i_enable, i_r1i, i_r1q, i_r2i, i_r2q, i_ready,
        input  o_valid, o_data_i, o_data_q, o_sof, o_eof, o_overflow
    );
endinterface

// File: rtl/rx_fft_framer.sv
// rx_fft_framer: requantizes two noisy complex samples per enabled beat
// (round-half-up, then saturate) and packs two beats into one 4-lane word for
// the parallel-4 FFT, tagging the first and last word of each NFFT-sample frame.
// A word that completes while the previous one is still stalled is dropped and
// o_overflow is set (sticky). Frame position follows the input sample stream,
// so dropped words still advance the word counter.
// Optional macro RX_FRAMER_STATS_EN adds o_sat_count, a saturating count of
// clipped components.
module rx_fft_framer #(
    parameter int NB_IN   = 16,
    parameter int NB_DROP = 4,
    parameter int NB_OUT  = 10,
    parameter int NFFT    = 16
) (
    input  logic             CLK100MHZ,
    input  logic             ck_rst,
    rx_fft_framer_if.slave   bus
);
    localparam int C_WORDS = NFFT / 4;
    localparam int CW      = (C_WORDS > 1) ? $clog2(C_WORDS) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(C_WORDS - 1);

    localparam logic signed [NB_IN:0] C_RND = (NB_IN+1)'(2 ** (NB_DROP - 1));
    localparam logic signed [NB_IN:0] C_MAX = (NB_IN+1)'(2 ** (NB_OUT - 1) - 1);
    localparam logic signed [NB_IN:0] C_MIN = ~C_MAX;

    typedef enum logic {
        PH_FIRST  = 1'b0,
        PH_SECOND = 1'b1
    } phase_t;

    // Rounded, shifted value before clamping; one guard bit keeps the
    // rounding offset from wrapping at the positive full-scale input.
    function automatic logic signed [NB_IN:0] rnd_shift(input logic [NB_IN-1:0] x);
        logic signed [NB_IN:0] v_sum;
        v_sum     = $signed({x[NB_IN-1], x}) + C_RND;
        rnd_shift = v_sum >>> NB_DROP;
    endfunction

    function automatic logic [NB_OUT-1:0] quant(input logic [NB_IN-1:0] x);
        logic signed [NB_IN:0] v_sh;
        v_sh = rnd_shift(x);
        if (v_sh > C_MAX) begin
            quant = C_MAX[NB_OUT-1:0];
        end else if (v_sh < C_MIN) begin
            quant = C_MIN[NB_OUT-1:0];
        end else begin
            quant = v_sh[NB_OUT-1:0];
        end
    endfunction

    function automatic logic sat_hit(input logic [NB_IN-1:0] x);
        logic signed [NB_IN:0] v_sh;
        v_sh    = rnd_shift(x);
        sat_hit = (v_sh > C_MAX) || (v_sh < C_MIN);
    endfunction

    phase_t              r_phase;
    logic [CW-1:0]       r_cnt;
    logic [2*NB_OUT-1:0] r_half_i;
    logic [2*NB_OUT-1:0] r_half_q;
    logic                r_valid;
    logic [4*NB_OUT-1:0] r_data_i;
    logic [4*NB_OUT-1:0] r_data_q;
    logic                r_sof;
    logic                r_eof;
    logic                r_overflow;

    logic [NB_OUT-1:0]   w_q_r1i;
    logic [NB_OUT-1:0]   w_q_r1q;
    logic [NB_OUT-1:0]   w_q_r2i;
    logic [NB_OUT-1:0]   w_q_r2q;
    logic                w_complete;
    logic                w_load;

    // Requantize the four incoming components.
    always_comb begin
        w_q_r1i = quant(bus.i_r1i);
        w_q_r1q = quant(bus.i_r1q);
        w_q_r2i = quant(bus.i_r2i);
        w_q_r2q = quant(bus.i_r2q);
    end

    // A word completes on the second beat; it is loaded only if the output
    // register is empty or being emptied this same cycle.
    always_comb begin
        w_complete = bus.i_enable && (r_phase == PH_SECOND);
        w_load     = w_complete && (!r_valid || bus.i_ready);
    end

    // Phase FSM, frame counter and registered output word.
    always_ff @(posedge CLK100MHZ) begin
        if (ck_rst) begin
            r_phase    <= PH_FIRST;
            r_cnt      <= '0;
            r_half_i   <= '0;
            r_half_q   <= '0;
            r_valid    <= 1'b0;
            r_data_i   <= '0;
            r_data_q   <= '0;
            r_sof      <= 1'b0;
            r_eof      <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (bus.i_enable) begin
                case (r_phase)
                    PH_FIRST: begin
                        r_half_i <= {w_q_r2i, w_q_r1i};
                        r_half_q <= {w_q_r2q, w_q_r1q};
                        r_phase  <= PH_SECOND;
                    end
                    PH_SECOND: begin
                        r_phase <= PH_FIRST;
                        r_cnt   <= (r_cnt == C_LAST) ? '0 : r_cnt + CW'(1);
                    end
                    default: r_phase <= PH_FIRST;
                endcase
            end

            if (w_load) begin
                r_valid  <= 1'b1;
                r_data_i <= {w_q_r2i, w_q_r1i, r_half_i};
                r_data_q <= {w_q_r2q, w_q_r1q, r_half_q};
                r_sof    <= (r_cnt == '0);
                r_eof    <= (r_cnt == C_LAST);
            end else if (r_valid && bus.i_ready) begin
                r_valid <= 1'b0;
            end

            // Completed word with nowhere to go: keep the held word, flag it.
            if (w_complete && !w_load) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign bus.o_valid    = r_valid;
    assign bus.o_data_i   = r_data_i;
    assign bus.o_data_q   = r_data_q;
    assign bus.o_sof      = r_sof;
    assign bus.o_eof      = r_eof;
    assign bus.o_overflow = r_overflow;

`ifdef RX_FRAMER_STATS_EN
    logic [15:0] r_sat_count;
    logic [2:0]  w_sat_n;
    logic [16:0] w_sat_sum;

    // Number of components clipped in the current beat and the widened sum.
    always_comb begin
        w_sat_n   = 3'(sat_hit(bus.i_r1i)) + 3'(sat_hit(bus.i_r1q))
                  + 3'(sat_hit(bus.i_r2i)) + 3'(sat_hit(bus.i_r2q));
        w_sat_sum = {1'b0, r_sat_count} + 17'(w_sat_n);
    end

    // Saturating clip counter, advanced on every accepted beat.
    always_ff @(posedge CLK100MHZ) begin
        if (ck_rst) begin
            r_sat_count <= '0;
        end else if (bus.i_enable) begin
            r_sat_count <= w_sat_sum[16] ? 16'hFFFF : w_sat_sum[15:0];
        end
    end

    assign bus.o_sat_count = r_sat_count;
`endif
endmodule

// File: tb/tb_rx_fft_framer.sv
// Directed bench for rx_fft_framer: reset, rounding, saturation, continuous
// framing, backpressure with overflow, and enable gaps.
// Sample value s on a ramp is driven as i = 16*s, q = -16*s so that the
// requantized lanes read back as s and -s.
module tb_rx_fft_framer;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    int   n_beat;

    rx_fft_framer_if bus ();

    rx_fft_framer dut (
        .CLK100MHZ (clk),
        .ck_rst    (rst),
        .bus       (bus)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] pk(input int a, input int b, input int c, input int d);
        pk = {10'(d), 10'(c), 10'(b), 10'(a)};
    endfunction

    // Driver: one beat of ramp samples s (r1) and s+1 (r2).
    task automatic drive_ramp(input int s);
        bus.i_enable = 1'b1;
        bus.i_r1i    = 16'(16 * s);
        bus.i_r1q    = 16'(-16 * s);
        bus.i_r2i    = 16'(16 * (s + 1));
        bus.i_r2q    = 16'(-16 * (s + 1));
    endtask

    task automatic drive_raw(input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] c, input logic [15:0] d);
        bus.i_enable = 1'b1;
        bus.i_r1i    = a;
        bus.i_r1q    = b;
        bus.i_r2i    = c;
        bus.i_r2q    = d;
    endtask

    // Expected word w of the ramp: samples 4w..4w+3.
    task automatic chk_ramp_word(input string tag, input int w);
        chk({tag, "_valid"}, 64'(bus.o_valid), 64'd1);
        chk({tag, "_di"}, 64'(bus.o_data_i), 64'(pk(4*w, 4*w+1, 4*w+2, 4*w+3)));
        chk({tag, "_dq"}, 64'(bus.o_data_q), 64'(pk(-4*w, -4*w-1, -4*w-2, -4*w-3)));
        chk({tag, "_sof"}, 64'(bus.o_sof), 64'((w % 4) == 0));
        chk({tag, "_eof"}, 64'(bus.o_eof), 64'((w % 4) == 3));
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        rst          = 1'b0;
        bus.i_enable = 1'b0;
        bus.i_r1i    = '0;
        bus.i_r1q    = '0;
        bus.i_r2i    = '0;
        bus.i_r2q    = '0;
        bus.i_ready  = 1'b0;

        // 1: reset held 3 cycles with active input beats
        rst = 1'b1;
        drive_raw(16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000);
        tick();
        tick();
        tick();
        chk("rst_valid", 64'(bus.o_valid), 64'd0);
        chk("rst_di", 64'(bus.o_data_i), 64'd0);
        chk("rst_dq", 64'(bus.o_data_q), 64'd0);
        chk("rst_sof", 64'(bus.o_sof), 64'd0);
        chk("rst_eof", 64'(bus.o_eof), 64'd0);
        chk("rst_ovf", 64'(bus.o_overflow), 64'd0);
`ifdef RX_FRAMER_STATS_EN
        chk("rst_satcnt", 64'(bus.o_sat_count), 64'd0);
`endif
        rst          = 1'b0;
        bus.i_enable = 1'b0;
        bus.i_ready  = 1'b1;
        tick();
        chk("idle_valid", 64'(bus.o_valid), 64'd0);

        // 2: rounding
        drive_raw(16'(100), 16'(104), 16'(-24), 16'(-8));
        tick();
        chk("rnd_beat1_valid", 64'(bus.o_valid), 64'd0);
        drive_raw(16'(24), 16'(-9), 16'(0), 16'(15));
        tick();
        chk("rnd_valid", 64'(bus.o_valid), 64'd1);
        chk("rnd_di", 64'(bus.o_data_i), 64'(pk(6, -1, 2, 0)));
        chk("rnd_dq", 64'(bus.o_data_q), 64'(pk(7, 0, -1, 1)));
        chk("rnd_sof", 64'(bus.o_sof), 64'd1);
        chk("rnd_eof", 64'(bus.o_eof), 64'd0);
        bus.i_enable = 1'b0;
        tick();
        chk("rnd_drop_valid", 64'(bus.o_valid), 64'd0);

        // 3: saturation (second word of the frame)
        drive_raw(16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000);
        tick();
        drive_raw(16'h8000, 16'h7FFF, 16'h0000, 16'h0000);
        tick();
        chk("sat_valid", 64'(bus.o_valid), 64'd1);
        chk("sat_di", 64'(bus.o_data_i), 64'(pk(511, 511, -512, 0)));
        chk("sat_dq", 64'(bus.o_data_q), 64'(pk(-512, -512, 511, 0)));
        chk("sat_sof", 64'(bus.o_sof), 64'd0);
        chk("sat_eof", 64'(bus.o_eof), 64'd0);
`ifdef RX_FRAMER_STATS_EN
        chk("sat_satcnt", 64'(bus.o_sat_count), 64'd6);
`endif
        bus.i_enable = 1'b0;
        tick();

        // 4: continuous framing, 12 words
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.i_ready = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            drive_ramp(2 * (k - 1));
            tick();
            if ((k % 2) == 0) chk_ramp_word("frm", k / 2 - 1);
            else chk("frm_gap_valid", 64'(bus.o_valid), 64'd0);
        end
        chk("frm_ovf", 64'(bus.o_overflow), 64'd0);
        // leave a half word pending, then reset over it
        drive_ramp(100);
        tick();
        rst = 1'b1;
        bus.i_enable = 1'b0;
        tick();
        rst = 1'b0;
        chk("midrst_valid", 64'(bus.o_valid), 64'd0);

        // 5: backpressure for 5 cycles, then release
        bus.i_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            drive_ramp(2 * (k - 1));
            tick();
            if (k == 1) begin
                chk("bp_first_valid", 64'(bus.o_valid), 64'd0);
            end else begin
                chk_ramp_word("bp_hold", 0);
                chk("bp_ovf", 64'(bus.o_overflow), 64'(k >= 4));
            end
        end
        bus.i_ready = 1'b1;
        for (int k = 6; k <= 10; k++) begin
            drive_ramp(2 * (k - 1));
            tick();
            if ((k % 2) == 0) chk_ramp_word("bp_rel", k / 2 - 1);
            else chk("bp_rel_valid", 64'(bus.o_valid), 64'd0);
        end
        chk("bp_ovf_sticky", 64'(bus.o_overflow), 64'd1);

        // 6: enable toggled every cycle, junk data on idle cycles
        bus.i_enable = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_beat = 0;
        for (int k = 1; k <= 32; k++) begin
            if ((k % 2) == 1) begin
                drive_ramp(2 * n_beat);
                n_beat++;
            end else begin
                bus.i_enable = 1'b0;
                bus.i_r1i    = 16'($urandom_range(0, 65535));
                bus.i_r1q    = 16'($urandom_range(0, 65535));
                bus.i_r2i    = 16'($urandom_range(0, 65535));
                bus.i_r2q    = 16'($urandom_range(0, 65535));
            end
            tick();
            if ((k % 4) == 3) chk_ramp_word("gap", (k - 3) / 4);
            else chk("gap_valid", 64'(bus.o_valid), 64'd0);
        end
        chk("gap_ovf", 64'(bus.o_overflow), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
